duart_bus_frontend: RTL and testbench

Parametrised host-bus front end for an N-channel DUART. It synchronises the asynchronous 68xx-style bus (_CS, R_W, address, data) into CLK. It converts each access into exactly one single-cycle read or write strobe to one channel, and returns read data on the bus. It owns the per-channel interrupt mask and status registers and drives the aggregated open-style _INT. It replaces the fixed two-block decode with a CHANNELS-wide decode and a proper access state machine.

---
 rtl/duart_bus_frontend.sv | 226 ++++++++++++++++++++++
 tb/tb_duart_bus_frontend.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/duart_bus_frontend.sv
// Host-bus front end for an N-channel DUART: synchronises the async 68xx bus and
// turns each access into one channel strobe. Owns the IMR/ISR registers. Optional macro: INT_LATCH_EN.
module duart_bus_frontend #(
    parameter int CHANNELS    = 2,
    parameter int CH_BITS     = 1,
    parameter int SYNC_STAGES = 3,
    parameter int ADDR_W      = 3 + CH_BITS
) (
    input  logic                  CLK,
    input  logic                  _RESET,
    input  logic [ADDR_W-1:0]     A,
    input  logic                  R_W,
    input  logic                  _CS,
    inout  wire  [7:0]            D,
    output logic                  _INT,
    output logic [CHANNELS-1:0]   CH_SEL,
    output logic                  CH_CTRL,
    output logic [1:0]            REG_ADDR,
    output logic                  WR_STB,
    output logic                  RD_STB,
    output logic [7:0]            WR_DATA,
    input  logic [8*CHANNELS-1:0] CH_RD_DATA,
    input  logic [CHANNELS-1:0]   FFULL,
    input  logic [CHANNELS-1:0]   TXRDY
);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACCESS, HOLD} state_t;

    logic [SYNC_STAGES-1:0] cs_sync_q, vld_sync_q, rw_sync_q;
    logic [ADDR_W-1:0]      a_sync_q [SYNC_STAGES];
    logic [7:0]             d_sync_q [SYNC_STAGES];

    state_t                 state_q, state_d;
    logic                   wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d;
    logic [CHANNELS-1:0]    ch_sel_q, ch_sel_d;
    logic                   ch_ctrl_q, ch_ctrl_d;
    logic [1:0]             reg_addr_q, reg_addr_d;
    logic [7:0]             wr_data_q, wr_data_d;
    logic [7:0]             rd_latch_q, rd_latch_d;
    logic [2*CHANNELS-1:0]  imr_q, imr_d;
    logic                   int_n_q, int_n_d;
    logic                   acc_rw_q, acc_rw_d, acc_valid_q, acc_valid_d;
    logic [CH_BITS-1:0]     acc_ch_q, acc_ch_d;

    logic                   cs_s, rw_s;
    logic [ADDR_W-1:0]      a_s;
    logic [7:0]             d_s;
    logic [CH_BITS-1:0]     cap_ch;
    logic [CHANNELS-1:0]    cap_hit;
    logic                   cap_owned;
    logic [2*CHANNELS-1:0]  isr_cur, isr_view, isr_int;
    logic [7:0]             rd_value;

    // The valid chain marks when the _CS chain holds real samples rather than reset values,
    // so a bus cycle already in progress at reset exit cannot be mistaken for a fresh one.
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            cs_sync_q  <= '1;
            vld_sync_q <= '0;
        end else begin
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], _CS};
            vld_sync_q <= {vld_sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_ff @(posedge CLK) begin
        rw_sync_q   <= {rw_sync_q[SYNC_STAGES-2:0], R_W};
        a_sync_q[0] <= A;
        d_sync_q[0] <= D;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            a_sync_q[i] <= a_sync_q[i-1];
            d_sync_q[i] <= d_sync_q[i-1];
        end
    end

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign rw_s      = rw_sync_q[SYNC_STAGES-1];
    assign a_s       = a_sync_q[SYNC_STAGES-1];
    assign d_s       = d_sync_q[SYNC_STAGES-1];
    assign cap_ch    = a_s[ADDR_W-1:3];
    assign cap_owned = a_s[2] && !a_s[1];

    always_comb begin
        isr_cur = '0;
        cap_hit = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            isr_cur[2*c +: 2] = {TXRDY[c], FFULL[c]};
            cap_hit[c]        = (cap_ch == CH_BITS'(c));
        end
    end

`ifdef INT_LATCH_EN
    logic [2*CHANNELS-1:0] isr_q, isr_d, src_prev_q, isr_clr;

    // A rising source edge is OR-ed in after the clear, so a coinciding set wins.
    always_comb isr_d = (isr_q & ~isr_clr) | (isr_cur & ~src_prev_q);
    assign isr_view = isr_q;
    assign isr_int  = isr_d;
`else
    assign isr_view = isr_cur;
    assign isr_int  = isr_cur;
`endif

    always_comb begin
        rd_value = 8'hFF;
        if (acc_valid_q) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (acc_ch_q == CH_BITS'(c)) begin
                    if (ch_ctrl_q && reg_addr_q == 2'd0)
                        rd_value = {6'b0, imr_q[2*c +: 2]};
                    else if (ch_ctrl_q && reg_addr_q == 2'd1)
                        rd_value = {6'b0, isr_view[2*c +: 2]};
                    else
                        rd_value = CH_RD_DATA[8*c +: 8];
                end
            end
        end
    end

    // Strobe and capture happen on the edge that enters ACCESS; owned registers and
    // the read latch update on the edge that leaves it.
    always_comb begin
        state_d     = state_q;
        wr_stb_d    = 1'b0;
        rd_stb_d    = 1'b0;
        ch_sel_d    = '0;
        ch_ctrl_d   = ch_ctrl_q;
        reg_addr_d  = reg_addr_q;
        wr_data_d   = wr_data_q;
        rd_latch_d  = rd_latch_q;
        imr_d       = imr_q;
        acc_rw_d    = acc_rw_q;
        acc_ch_d    = acc_ch_q;
        acc_valid_d = acc_valid_q;
`ifdef INT_LATCH_EN
        isr_clr     = '0;
`endif
        case (state_q)
            WAIT_IDLE: if (vld_sync_q[SYNC_STAGES-1] && cs_s) state_d = IDLE;
            IDLE: begin
                if (!cs_s) begin
                    state_d     = ACCESS;
                    ch_ctrl_d   = a_s[2];
                    reg_addr_d  = a_s[1:0];
                    acc_rw_d    = rw_s;
                    acc_ch_d    = cap_ch;
                    acc_valid_d = |cap_hit;
                    if (!rw_s) wr_data_d = d_s;
                    if (|cap_hit && !cap_owned) begin
                        wr_stb_d = !rw_s;
                        rd_stb_d = rw_s;
                        ch_sel_d = cap_hit;
                    end
                end
            end
            ACCESS: begin
                state_d = HOLD;
                if (acc_rw_q) begin
                    rd_latch_d = rd_value;
                end else if (acc_valid_q && ch_ctrl_q) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (acc_ch_q == CH_BITS'(c)) begin
                            if (reg_addr_q == 2'd0) imr_d[2*c +: 2] = wr_data_q[1:0];
`ifdef INT_LATCH_EN
                            if (reg_addr_q == 2'd1) isr_clr[2*c +: 2] = wr_data_q[1:0];
`endif
                        end
                    end
                end
            end
            HOLD:    if (cs_s) state_d = IDLE;
            default: state_d = WAIT_IDLE;
        endcase
        int_n_d = ~|(isr_int & imr_q);
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state_q     <= WAIT_IDLE;
            wr_stb_q    <= 1'b0;
            rd_stb_q    <= 1'b0;
            ch_sel_q    <= '0;
            ch_ctrl_q   <= 1'b0;
            reg_addr_q  <= 2'd0;
            wr_data_q   <= 8'h00;
            rd_latch_q  <= 8'hFF;
            imr_q       <= '0;
            int_n_q     <= 1'b1;
            acc_rw_q    <= 1'b0;
            acc_ch_q    <= '0;
            acc_valid_q <= 1'b0;
`ifdef INT_LATCH_EN
            isr_q       <= '0;
            src_prev_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_stb_q    <= wr_stb_d;
            rd_stb_q    <= rd_stb_d;
            ch_sel_q    <= ch_sel_d;
            ch_ctrl_q   <= ch_ctrl_d;
            reg_addr_q  <= reg_addr_d;
            wr_data_q   <= wr_data_d;
            rd_latch_q  <= rd_latch_d;
            imr_q       <= imr_d;
            int_n_q     <= int_n_d;
            acc_rw_q    <= acc_rw_d;
            acc_ch_q    <= acc_ch_d;
            acc_valid_q <= acc_valid_d;
`ifdef INT_LATCH_EN
            isr_q       <= isr_d;
            src_prev_q  <= isr_cur;
`endif
        end
    end

    assign D        = (!_CS && R_W) ? rd_latch_q : 8'bz;
    assign _INT     = int_n_q;
    assign CH_SEL   = ch_sel_q;
    assign CH_CTRL  = ch_ctrl_q;
    assign REG_ADDR = reg_addr_q;
    assign WR_STB   = wr_stb_q;
    assign RD_STB   = rd_stb_q;
    assign WR_DATA  = wr_data_q;

endmodule

// File: tb/tb_duart_bus_frontend.sv
// Bench for duart_bus_frontend with three channels; a behavioural model of the
// register map and interrupt rules predicts every expected value.
module tb_duart_bus_frontend;

    localparam int CHN  = 3;
    localparam int CHB  = 2;
    localparam int SYNC = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  a = '0;
    logic        r_w = 1'b0;
    logic        cs_n = 1'b1;
    logic [7:0]  d_drv = 8'h3C;
    logic        d_oe = 1'b1;
    wire  [7:0]  d_bus;
    logic        int_n;
    logic [2:0]  ch_sel;
    logic        ch_ctrl;
    logic [1:0]  reg_addr;
    logic        wr_stb, rd_stb;
    logic [7:0]  wr_data;
    logic [23:0] ch_rd_data = 24'h33_77_C3;
    logic [2:0]  ffull = '0;
    logic [2:0]  txrdy = '0;

    int total = 0;
    int passed = 0;

    logic [1:0] imr_m [CHN];
    logic [1:0] isr_m [CHN];

    assign d_bus = d_oe ? d_drv : 8'bz;

    duart_bus_frontend #(.CHANNELS(CHN), .CH_BITS(CHB), .SYNC_STAGES(SYNC)) dut (
        .CLK(clk), ._RESET(reset_n), .A(a), .R_W(r_w), ._CS(cs_n), .D(d_bus),
        ._INT(int_n), .CH_SEL(ch_sel), .CH_CTRL(ch_ctrl), .REG_ADDR(reg_addr),
        .WR_STB(wr_stb), .RD_STB(rd_stb), .WR_DATA(wr_data),
        .CH_RD_DATA(ch_rd_data), .FFULL(ffull), .TXRDY(txrdy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic expInt();
        logic any = 1'b0;
        for (int c = 0; c < CHN; c++) any |= |(isr_m[c] & imr_m[c]);
        return ~any;
    endfunction

    function automatic logic [7:0] predictRead(input logic [4:0] addr);
        int c = int'(addr[4:3]);
        if (c >= CHN) return 8'hFF;
        if (addr[2] && addr[1:0] == 2'd0) return {6'b0, imr_m[c]};
        if (addr[2] && addr[1:0] == 2'd1) return {6'b0, isr_m[c]};
        return ch_rd_data[c*8 +: 8];
    endfunction

    task automatic resetModel();
        for (int c = 0; c < CHN; c++) begin
            imr_m[c] = 2'b00;
            isr_m[c] = {txrdy[c], ffull[c]};
        end
    endtask

    task automatic setStatus(input logic [2:0] ff, input logic [2:0] tx);
        @(negedge clk);
        for (int c = 0; c < CHN; c++) begin
`ifdef INT_LATCH_EN
            isr_m[c] = isr_m[c] | ({tx[c], ff[c]} & ~{txrdy[c], ffull[c]});
`else
            isr_m[c] = {tx[c], ff[c]};
`endif
        end
        ffull = ff;
        txrdy = tx;
    endtask

    task automatic applyStimulus(input logic [4:0] addr, input logic rw, input logic [7:0] wdata,
                                 output int wr_n, output int rd_n, output int strobe_edge,
                                 output logic [2:0] sel_at, output logic [2:0] sel_or,
                                 output logic ctrl_at, output logic [1:0] reg_at,
                                 output logic [7:0] wrd_at, output logic [7:0] d_early,
                                 output logic [7:0] d_late);
        @(negedge clk);
        a = addr; r_w = rw; d_drv = wdata; d_oe = !rw;
        @(negedge clk);
        cs_n = 1'b0;
        wr_n = 0; rd_n = 0; strobe_edge = 0;
        sel_at = '0; sel_or = '0; ctrl_at = 1'b0; reg_at = '0; wrd_at = '0;
        d_early = '0; d_late = '0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            if ((wr_stb || rd_stb) && strobe_edge == 0) begin
                strobe_edge = e;
                sel_at = ch_sel; ctrl_at = ch_ctrl; reg_at = reg_addr; wrd_at = wr_data;
            end
            wr_n += int'(wr_stb);
            rd_n += int'(rd_stb);
            sel_or |= ch_sel;
            if (e == SYNC + 2) d_early = d_bus;
            if (e == 10) d_late = d_bus;
        end
        @(negedge clk);
        cs_n = 1'b1; d_drv = 8'h3C; d_oe = 1'b1;
        #1;
    endtask

    task automatic doAccess(input string tag, input logic [4:0] addr, input logic rw, input logic [7:0] wdata);
        int c = int'(addr[4:3]);
        logic valid = (c < CHN);
        logic owned = addr[2] && (addr[1:0] < 2'd2);
        logic fwd = valid && !owned;
        logic [7:0] exp_rd = predictRead(addr);
        int wr_n, rd_n, se;
        logic [2:0] sel_at, sel_or;
        logic ctrl_at;
        logic [1:0] reg_at;
        logic [7:0] wrd_at, d_early, d_late;
        applyStimulus(addr, rw, wdata, wr_n, rd_n, se, sel_at, sel_or, ctrl_at, reg_at, wrd_at, d_early, d_late);
        checkOutput({tag, "_wr_cnt"}, wr_n, (fwd && !rw) ? 1 : 0);
        checkOutput({tag, "_rd_cnt"}, rd_n, (fwd && rw) ? 1 : 0);
        checkOutput({tag, "_sel_any"}, sel_or, fwd ? (3'b001 << c) : 3'b000);
        if (fwd) begin
            checkOutput({tag, "_strobe_edge"}, se, SYNC + 1);
            checkOutput({tag, "_sel"}, sel_at, 3'b001 << c);
            checkOutput({tag, "_ctrl"}, ctrl_at, addr[2]);
            checkOutput({tag, "_reg_addr"}, reg_at, addr[1:0]);
            if (!rw) checkOutput({tag, "_wr_data"}, wrd_at, wdata);
        end
        if (rw) begin
            checkOutput({tag, "_d_early"}, d_early, exp_rd);
            checkOutput({tag, "_d_late"}, d_late, exp_rd);
            checkOutput({tag, "_d_released"}, d_bus, 8'h3C);
        end
        if (!rw && valid && addr[2] && addr[1:0] == 2'd0) imr_m[c] = wdata[1:0];
`ifdef INT_LATCH_EN
        if (!rw && valid && addr[2] && addr[1:0] == 2'd1) isr_m[c] = isr_m[c] & ~wdata[1:0];
`endif
        repeat (SYNC + 3) @(posedge clk);
        #1;
        checkOutput({tag, "_int"}, int_n, expInt());
    endtask

    initial begin
        int strobes;
        for (int c = 0; c < CHN; c++) begin
            imr_m[c] = 2'b00;
            isr_m[c] = 2'b00;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_wr_stb", wr_stb, 1'b0);
        checkOutput("rst_rd_stb", rd_stb, 1'b0);
        checkOutput("rst_ch_sel", ch_sel, 3'b000);
        checkOutput("rst_ch_ctrl", ch_ctrl, 1'b0);
        checkOutput("rst_reg_addr", reg_addr, 2'd0);
        checkOutput("rst_wr_data", wr_data, 8'h00);
        checkOutput("rst_int", int_n, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        resetModel();
        repeat (6) @(posedge clk);

        doAccess("wr_ch1_d3", 5'b01011, 1'b0, 8'h5A);
        doAccess("rd_ch0_d0", 5'b00000, 1'b1, 8'h00);

        setStatus(3'b000, 3'b010);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("txrdy1_unmasked_int", int_n, expInt());
        doAccess("imr_wr_ch0", 5'b00100, 1'b0, 8'h01);
        setStatus(3'b001, 3'b010);
        #1;
        checkOutput("ffull0_int_before_edge", int_n, 1'b1);
        @(posedge clk); #1;
        checkOutput("ffull0_int_after_edge", int_n, expInt());
        checkOutput("ffull0_int_low", int_n, 1'b0);
        doAccess("imr_rd_ch0", 5'b00100, 1'b1, 8'h00);
        doAccess("isr_rd_ch0", 5'b00101, 1'b1, 8'h00);
        doAccess("isr_rd_ch1", 5'b01101, 1'b1, 8'h00);
        doAccess("bad_ch_wr", 5'b11011, 1'b0, 8'hA7);
        doAccess("bad_ch_rd", 5'b11011, 1'b1, 8'h00);
        doAccess("bad_ch_imr_rd", 5'b11100, 1'b1, 8'h00);
        doAccess("ctrl2_ch1_wr", 5'b01110, 1'b0, 8'h96);
        doAccess("ctrl3_ch2_rd", 5'b10111, 1'b1, 8'h00);

`ifdef INT_LATCH_EN
        setStatus(3'b000, 3'b000);
        for (int c = 0; c < CHN; c++) doAccess("isr_clear_all", {2'(c), 3'b101}, 1'b0, 8'h03);
        setStatus(3'b001, 3'b000);
        setStatus(3'b000, 3'b000);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("latch_int_held", int_n, expInt());
        checkOutput("latch_int_low", int_n, 1'b0);
        doAccess("latch_isr_rd", 5'b00101, 1'b1, 8'h00);
        doAccess("latch_w1c", 5'b00101, 1'b0, 8'h01);
        checkOutput("latch_int_cleared", int_n, 1'b1);
`else
        doAccess("isr_wr_ignored", 5'b00101, 1'b0, 8'h03);
        doAccess("isr_rd_after_wr", 5'b00101, 1'b1, 8'h00);
`endif

        setStatus(3'b001, 3'b000);
        @(negedge clk);
        a = 5'b00000; r_w = 1'b1; d_oe = 1'b0; cs_n = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_d_latch", d_bus, 8'hFF);
        checkOutput("rst_mid_int", int_n, 1'b1);
        checkOutput("rst_mid_rd_stb", rd_stb, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        resetModel();
        strobes = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            strobes += int'(wr_stb) + int'(rd_stb);
        end
        checkOutput("rst_exit_no_strobe", strobes, 0);
        checkOutput("rst_exit_int", int_n, expInt());
        @(negedge clk);
        cs_n = 1'b1; d_drv = 8'h3C; d_oe = 1'b1;
        repeat (6) @(posedge clk);
        doAccess("post_rst_imr_rd", 5'b00100, 1'b1, 8'h00);
        doAccess("post_rst_data_rd", 5'b00000, 1'b1, 8'h00);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                setStatus(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
                @(posedge clk); #1;
                checkOutput("rand_status_int", int_n, expInt());
            end
            ch_rd_data = 24'($urandom);
            doAccess("rand", 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
